// File: rtl/grad_seq_ctrl.sv
`timescale 1ns/1ps
// grad_seq_ctrl: frame sequencer for the Sobel gradient stage.
// Walks a frame as FILL (rows 0-1), RUN (rows 2..IMG_H-1) and FLUSH (bottom pad
// row), handshakes gray pixels in, tracks row/column and produces the datapath
// controls (state, en_1, edg) plus pipeline-aligned valid/last flags.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, abort      frame control from the top controller
//   pix_vld / pix_rdy pixel handshake with the gray source
//   state             one-hot: 1000 IDLE, 0001 FILL, 0010 RUN, 0100 FLUSH
//   en_1, edg         pixel-accept strobe and border-column flag
//   col, row          current position (row reads IMG_H during FLUSH)
//   busy, done        frame in progress / one-cycle drained pulse
//   grad_out_vld/last valid interior gradient / final gradient of the frame
module grad_seq_ctrl #(
    parameter int unsigned IMG_W    = 1024,
    parameter int unsigned IMG_H    = 768,
    parameter int unsigned CW       = 11,
    parameter int unsigned PIPE_LAT = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          pix_vld,
    output logic          pix_rdy,
    output logic [3:0]    state,
    output logic          en_1,
    output logic          edg,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          busy,
    output logic          grad_out_vld,
    output logic          grad_out_last,
    output logic          done
);

    localparam logic [3:0] ST_IDLE  = 4'b1000;
    localparam logic [3:0] ST_FILL  = 4'b0001;
    localparam logic [3:0] ST_RUN   = 4'b0010;
    localparam logic [3:0] ST_FLUSH = 4'b0100;

    localparam int unsigned DW = $clog2(PIPE_LAT + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_PRE  = CW'(IMG_W - 2);
    localparam logic [CW-1:0] ROW_FILL = CW'(1);
    localparam logic [CW-1:0] ROW_RUN  = CW'(IMG_H - 1);

    logic [3:0]          state_nxt;
    logic                pix_rdy_nxt;
    logic                step;
    logic                col_last;
    logic                start_ok;
    logic                g;
    logic                gl;
    logic [DW-1:0]       dcnt;
    logic [PIPE_LAT-1:0] vld_sr;
    logic [PIPE_LAT-1:0] last_sr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_nxt   = state;
        pix_rdy_nxt = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_ok) state_nxt = ST_FILL;
                ST_FILL:  if (step && col_last && row == ROW_FILL) state_nxt = ST_RUN;
                ST_RUN:   if (step && col_last && row == ROW_RUN) state_nxt = ST_FLUSH;
                ST_FLUSH: if (col_last) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
        pix_rdy_nxt = (state_nxt == ST_FILL) || (state_nxt == ST_RUN);
    end

    // Output / control decode from the current state and position
    always_comb begin
        en_1     = pix_vld & pix_rdy;
        col_last = (col == COL_LAST);
        start_ok = (state == ST_IDLE) & start & ~busy;
        edg      = 1'b0;
        step     = 1'b0;
        case (state)
            ST_FILL, ST_RUN: begin
                step = en_1;
                edg  = (col == '0) | col_last;
            end
            ST_FLUSH: begin
                step = 1'b1;
                edg  = (col == '0) | col_last;
            end
            default: ;
        endcase
        // FLUSH is the bottom pad row: it completes interior outputs without new pixels
        g  = ((state == ST_RUN) & en_1 & ~edg) | ((state == ST_FLUSH) & ~edg);
        gl = (state == ST_FLUSH) & (col == COL_PRE);
        grad_out_vld  = vld_sr[PIPE_LAT-1];
        grad_out_last = last_sr[PIPE_LAT-1];
    end

    // Position counters, handshake, drain counter and valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row     <= '0;
            col     <= '0;
            pix_rdy <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dcnt    <= '0;
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            pix_rdy <= pix_rdy_nxt;
            done    <= 1'b0;
            if (abort) begin
                row     <= '0;
                col     <= '0;
                busy    <= 1'b0;
                dcnt    <= '0;
                vld_sr  <= '0;
                last_sr <= '0;
            end else begin
                vld_sr  <= PIPE_LAT'({vld_sr, g});
                last_sr <= PIPE_LAT'({last_sr, gl});
                if (start_ok) begin
                    row  <= '0;
                    col  <= '0;
                    busy <= 1'b1;
                end else if (state == ST_FLUSH && col_last) begin
                    row  <= '0;
                    col  <= '0;
                    dcnt <= DW'(PIPE_LAT);
                end else if (step) begin
                    if (col_last) begin
                        col <= '0;
                        row <= row + CW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                // Drain: busy stays high until the last gradient has left the pipe
                if (state == ST_IDLE && dcnt != '0) begin
                    dcnt <= dcnt - DW'(1);
                    if (dcnt == DW'(1)) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_grad_seq_ctrl.sv
`timescale 1ns/1ps
// Directed bench for grad_seq_ctrl on an 8x4 frame.
module tb_grad_seq_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned CWT = 4;
    localparam int unsigned PL = 5;

    localparam logic [3:0] S_IDLE  = 4'b1000;
    localparam logic [3:0] S_FILL  = 4'b0001;
    localparam logic [3:0] S_RUN   = 4'b0010;
    localparam logic [3:0] S_FLUSH = 4'b0100;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic           pix_vld;
    logic           pix_rdy;
    logic [3:0]     state;
    logic           en_1;
    logic           edg;
    logic [CWT-1:0] col;
    logic [CWT-1:0] row;
    logic           busy;
    logic           grad_out_vld;
    logic           grad_out_last;
    logic           done;

    grad_seq_ctrl #(
        .IMG_W(W), .IMG_H(H), .CW(CWT), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pix_vld(pix_vld), .pix_rdy(pix_rdy), .state(state), .en_1(en_1),
        .edg(edg), .col(col), .row(row), .busy(busy),
        .grad_out_vld(grad_out_vld), .grad_out_last(grad_out_last), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int n_en, n_fill, n_run, n_flush, n_vld, n_last, n_lastvld;
    int bad_en, bad_edg, bad_frz, bad_bnd;
    int t_idle, t_done, busy_at_done, busy_pre_done;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a frame and step it until done (bounded); toggle=1 stalls every other cycle
    task automatic run_frame(input bit toggle);
        logic [3:0]     ps;
        logic [CWT-1:0] pc;
        logic [CWT-1:0] pr;
        logic           pv;
        logic           pb;
        bit             fin;
        n_en = 0; n_fill = 0; n_run = 0; n_flush = 0; n_vld = 0; n_last = 0;
        n_lastvld = 0; bad_en = 0; bad_edg = 0; bad_frz = 0; bad_bnd = 0;
        t_idle = -1; t_done = -1; busy_at_done = -1; busy_pre_done = -1;
        ps = S_IDLE; pc = '0; pr = '0; pv = 1'b1; pb = 1'b0; fin = 0;
        @(negedge clk);
        start = 1'b1;
        pix_vld = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            pix_vld = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            if (en_1) n_en++;
            if (en_1 && !pix_vld) bad_en++;
            case (state)
                S_FILL:  n_fill++;
                S_RUN:   n_run++;
                S_FLUSH: n_flush++;
                default: ;
            endcase
            if (grad_out_vld) n_vld++;
            if (grad_out_last) n_last++;
            if (grad_out_vld && grad_out_last) n_lastvld++;
            if (edg !== ((state != S_IDLE) && (col == 0 || col == CWT'(W - 1)))) bad_edg++;
            if (col > CWT'(W - 1) || row > CWT'(H)) bad_bnd++;
            if ((ps == S_FILL || ps == S_RUN) && !pv &&
                (state !== ps || col !== pc || row !== pr)) bad_frz++;
            if (ps == S_FLUSH && state == S_IDLE) t_idle = c;
            if (done) begin
                t_done = c;
                busy_at_done = int'(busy);
                busy_pre_done = int'(pb);
                fin = 1;
            end
            ps = state; pc = col; pr = row; pv = pix_vld; pb = busy;
            @(negedge clk);
        end
        pix_vld = 1'b0;
    endtask

    initial begin
        bit found;
        int nv;
        int nd;
        logic [CWT-1:0] rc;
        logic [CWT-1:0] rr;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_vld = 1'b0;
        #12;
        check("rst_state", int'(state), int'(S_IDLE));
        check("rst_rowcol", int'({row, col}), 0);
        check("rst_flags", int'({pix_rdy, en_1, edg, busy, grad_out_vld, grad_out_last, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: continuous frame
        run_frame(1'b0);
        check("t1_en", n_en, 32);
        check("t1_fill", n_fill, 16);
        check("t1_run", n_run, 16);
        check("t1_flush", n_flush, 8);
        check("t1_vld", n_vld, 18);
        check("t1_last", n_last, 1);
        check("t1_last_vld", n_lastvld, 1);
        check("t1_idle_cyc", t_idle, 40);
        check("t1_drain", t_done - t_idle, int'(PL));
        check("t1_busy_done", busy_at_done, 0);
        check("t1_busy_pre", busy_pre_done, 1);
        check("t1_edg", bad_edg, 0);
        #1;
        check("t1_done_pulse", int'(done), 0);

        // 2: alternating stalls
        run_frame(1'b1);
        check("t2_en", n_en, 32);
        check("t2_flush", n_flush, 8);
        check("t2_vld", n_vld, 18);
        check("t2_last_vld", n_lastvld, 1);
        check("t2_en_nopix", bad_en, 0);
        check("t2_freeze", bad_frz, 0);
        check("t2_bounds", bad_bnd, 0);
        check("t2_edg", bad_edg, 0);
        check("t2_done_seen", int'(t_done >= 0), 1);

        // 4: abort at row 2 col 3 in RUN
        @(negedge clk);
        start = 1'b1; pix_vld = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (state == S_RUN && row == 2 && col == 3) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("t4_reach", int'(found), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("t4_state", int'(state), int'(S_IDLE));
        check("t4_busy", int'(busy), 0);
        check("t4_rdy", int'(pix_rdy), 0);
        check("t4_rowcol", int'({row, col}), 0);
        nv = 0; nd = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (grad_out_vld) nv++;
            if (done) nd++;
        end
        check("t4_no_vld", nv, 0);
        check("t4_no_done", nd, 0);
        run_frame(1'b0);
        check("t4_refr_vld", n_vld, 18);
        check("t4_refr_drain", t_done - t_idle, int'(PL));

        // 5: start ignored while busy; start+abort in IDLE
        @(negedge clk);
        start = 1'b1; pix_vld = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (state == S_RUN && col == 4) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("t5_reach_run", int'(found), 1);
        pix_vld = 1'b0;
        start = 1'b1;
        rc = col; rr = row;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t5_run_state", int'(state), int'(S_RUN));
        check("t5_run_col", int'(col), int'(rc));
        check("t5_run_row", int'(row), int'(rr));
        pix_vld = 1'b1;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (state == S_IDLE) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("t5_reach_idle", int'(found), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t5_drain_state", int'(state), int'(S_IDLE));
        check("t5_drain_busy", int'(busy), 1);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (done) begin
                found = 1;
                break;
            end
        end
        check("t5_done", int'(found), 1);
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        check("t5_abort_start", int'(state), int'(S_IDLE));
        check("t5_abort_busy", int'(busy), 0);

        // 6: async reset during FLUSH
        @(negedge clk);
        start = 1'b1; pix_vld = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (state == S_FLUSH && col == 2) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("t6_reach_flush", int'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_state", int'(state), int'(S_IDLE));
        check("t6_rowcol", int'({row, col}), 0);
        check("t6_flags", int'({pix_rdy, en_1, edg, busy, grad_out_vld, grad_out_last, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("t6_post_state", int'(state), int'(S_IDLE));
        check("t6_post_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
